// File: rtl/spi_slave_single_pkg.sv
// Shared SPI definitions: FSM encoding, mode constants and edge-role helper.
// Also used by the SPI controller block.
package spi_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // Mode numbering is {CPOL, CPHA}.
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic logic sample_on_rise(input int cpol, input int cpha);
      logic [1:0] mode;
      mode = {cpol[0], cpha[0]};
      case (mode)
         SPI_MODE0, SPI_MODE3: return 1'b1;
         SPI_MODE1, SPI_MODE2: return 1'b0;
         default:              return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/spi_slave_single_sync_edge_det.sv
// Two-flop synchronizer with registered rise/fall strobes for one async pin.
// The strobes appear three clkIn cycles after the pin edge; levelOut is aligned with them.
module sync_edge_det
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clkIn,
   input  logic rstIn,
   input  logic dIn,
   output logic levelOut,
   output logic riseOut,
   output logic fallOut
);

   logic meta_q, sync_q, prev_q, rise_q, fall_q;

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= dIn;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign levelOut = prev_q;
   assign riseOut  = rise_q;
   assign fallOut  = fall_q;

endmodule

// File: rtl/spi_slave_single.sv
// Single-lane SPI peripheral, fully oversampled in the clkIn domain.
// LSB-first full-duplex words with a one-deep TX holding register.
module spi_slave_single
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    CPOL       = 0,
   parameter int                    CPHA       = 0,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
   input  logic                  clkIn,
   input  logic                  rstIn,
   input  logic                  sclkIn,
   input  logic                  csLowIn,
   input  logic                  mosiIn,
   output logic                  misoOut,
   output logic                  misoEnOut,
   input  logic [DATA_WIDTH-1:0] txDataIn,
   input  logic                  txWrEnIn,
   output logic                  txRdyOut,
   output logic [DATA_WIDTH-1:0] rxDataOut,
   output logic                  rxValidOut,
   output logic                  txUndOut
);

   localparam logic           SAMPLE_ON_RISE = sample_on_rise(CPOL, CPHA);
   localparam int             CNT_W          = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(DATA_WIDTH - 1);

   logic sclkLevel, sclkRise, sclkFall;
   logic csLevel, csRise, csFall;
   logic mosiLevel, mosiRise, mosiFall;
   logic unusedEdges;

   sync_edge_det #(.RST_VAL(CPOL != 0)) u_sync_sclk (
      .clkIn(clkIn), .rstIn(rstIn), .dIn(sclkIn),
      .levelOut(sclkLevel), .riseOut(sclkRise), .fallOut(sclkFall)
   );

   sync_edge_det #(.RST_VAL(1'b1)) u_sync_cs (
      .clkIn(clkIn), .rstIn(rstIn), .dIn(csLowIn),
      .levelOut(csLevel), .riseOut(csRise), .fallOut(csFall)
   );

   sync_edge_det #(.RST_VAL(1'b0)) u_sync_mosi (
      .clkIn(clkIn), .rstIn(rstIn), .dIn(mosiIn),
      .levelOut(mosiLevel), .riseOut(mosiRise), .fallOut(mosiFall)
   );

   assign unusedEdges = ^{sclkLevel, csLevel, mosiRise, mosiFall};

   logic sampleEdge, shiftEdge;
   assign sampleEdge = SAMPLE_ON_RISE ? sclkRise : sclkFall;
   assign shiftEdge  = SAMPLE_ON_RISE ? sclkFall : sclkRise;

   state_e                  state_q;
   logic [CNT_W-1:0]        bitCnt_q;
   logic [DATA_WIDTH-1:0]   hold_q, txShift_q, rxShift_q, rxData_q;
   logic                    txRdy_q, rxValid_q, txUnd_q, miso_q, misoEn_q;

   logic                    doLoad_d;
   logic [DATA_WIDTH-1:0]   loadWord_d;
   logic [DATA_WIDTH-1:0]   rxNext_d;

   // A word load happens at CS fall for CPHA=0, otherwise on a shift edge at a word boundary.
   always_comb begin
      doLoad_d = 1'b0;
      if (state_q == ST_IDLE) begin
         doLoad_d = csFall && (CPHA == 0);
      end else begin
         doLoad_d = !csRise && shiftEdge && (bitCnt_q == '0);
      end
   end

   assign loadWord_d = txRdy_q ? DEFAULT_TX : hold_q;
   assign rxNext_d   = {mosiLevel, rxShift_q[DATA_WIDTH-1:1]};

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q   <= ST_IDLE;
         bitCnt_q  <= '0;
         misoEn_q  <= 1'b0;
         miso_q    <= 1'b0;
         txRdy_q   <= 1'b1;
         rxData_q  <= '0;
         rxValid_q <= 1'b0;
         txUnd_q   <= 1'b0;
      end else begin
         rxValid_q <= 1'b0;
         txUnd_q   <= 1'b0;

         if (doLoad_d) begin
            txShift_q <= loadWord_d >> 1;
            miso_q    <= loadWord_d[0];
            txRdy_q   <= 1'b1;
            txUnd_q   <= txRdy_q;
         end
         // A write alongside an underrun load still lands for the following word.
         if (txWrEnIn && txRdy_q) begin
            hold_q  <= txDataIn;
            txRdy_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               bitCnt_q <= '0;
               misoEn_q <= 1'b0;
               if (csFall) begin
                  misoEn_q <= 1'b1;
                  state_q  <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (csRise) begin
                  state_q  <= ST_IDLE;
                  misoEn_q <= 1'b0;
                  bitCnt_q <= '0;
               end else if (sampleEdge) begin
                  rxShift_q <= rxNext_d;
                  if (bitCnt_q == LAST_BIT) begin
                     bitCnt_q  <= '0;
                     rxData_q  <= rxNext_d;
                     rxValid_q <= 1'b1;
                  end else begin
                     bitCnt_q <= bitCnt_q + CNT_W'(1);
                  end
               end else if (shiftEdge && (bitCnt_q != '0)) begin
                  miso_q    <= txShift_q[0];
                  txShift_q <= txShift_q >> 1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign misoOut    = miso_q;
   assign misoEnOut  = misoEn_q;
   assign txRdyOut   = txRdy_q;
   assign rxDataOut  = rxData_q;
   assign rxValidOut = rxValid_q;
   assign txUndOut   = txUnd_q;

endmodule
